// File: rtl/div_unit.sv
// rtl/div_unit.sv - multi-cycle radix-2 restoring divider for DIV/DIVU
// Produces {remainder, quotient}; result is held until execute drops start_i.
module div_unit #(
  parameter int DataWidth = 32,
  parameter int CntWidth  = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   signed_div_i,
  input  logic [DataWidth-1:0]   opdata1_i,
  input  logic [DataWidth-1:0]   opdata2_i,
  input  logic                   start_i,
  input  logic                   annul_i,
  output logic [2*DataWidth-1:0] result_o,
  output logic                   ready_o
);

  typedef enum logic [1:0] {
    ST_FREE   = 2'd0,
    ST_BYZERO = 2'd1,
    ST_ON     = 2'd2,
    ST_END    = 2'd3
  } state_e;

  state_e                 state_q;
  logic [CntWidth-1:0]    cnt_q;
  logic [DataWidth-1:0]   divisor_q;
  logic [2*DataWidth-1:0] partial_q;
  logic                   neg_quo_q;
  logic                   neg_rem_q;
  logic [2*DataWidth-1:0] result_q;
  logic                   ready_q;

  logic [DataWidth-1:0]   op1_mag;
  logic [DataWidth-1:0]   op2_mag;
  logic [DataWidth:0]     trial;
  logic [DataWidth-1:0]   quo_fix;
  logic [DataWidth-1:0]   rem_fix;

  always_comb begin
    op1_mag = (signed_div_i && opdata1_i[DataWidth-1]) ? (~opdata1_i + 1'b1) : opdata1_i;
    op2_mag = (signed_div_i && opdata2_i[DataWidth-1]) ? (~opdata2_i + 1'b1) : opdata2_i;
    // Shifted-in remainder can reach 33 bits; bit DataWidth of the difference is the borrow.
    trial   = partial_q[2*DataWidth-1:DataWidth-1] - {1'b0, divisor_q};
    quo_fix = neg_quo_q ? (~partial_q[DataWidth-1:0] + 1'b1) : partial_q[DataWidth-1:0];
    rem_fix = neg_rem_q ? (~partial_q[2*DataWidth-1:DataWidth] + 1'b1)
                        : partial_q[2*DataWidth-1:DataWidth];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_FREE;
      cnt_q     <= '0;
      divisor_q <= '0;
      partial_q <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
      ready_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_FREE: begin
          ready_q  <= 1'b0;
          result_q <= '0;
          if (start_i && !annul_i) begin
            divisor_q <= op2_mag;
            partial_q <= {{DataWidth{1'b0}}, op1_mag};
            neg_quo_q <= signed_div_i && (opdata1_i[DataWidth-1] ^ opdata2_i[DataWidth-1]);
            neg_rem_q <= signed_div_i && opdata1_i[DataWidth-1];
            cnt_q     <= '0;
            state_q   <= (opdata2_i == '0) ? ST_BYZERO : ST_ON;
          end
        end
        ST_BYZERO: begin
          result_q <= '0;
          ready_q  <= 1'b1;
          state_q  <= ST_END;
        end
        ST_ON: begin
          if (annul_i) begin
            state_q  <= ST_FREE;
            cnt_q    <= '0;
            result_q <= '0;
            ready_q  <= 1'b0;
          end else if (cnt_q != CntWidth'(DataWidth)) begin
            if (trial[DataWidth]) begin
              partial_q <= {partial_q[2*DataWidth-2:0], 1'b0};
            end else begin
              partial_q <= {trial[DataWidth-1:0], partial_q[DataWidth-2:0], 1'b1};
            end
            cnt_q <= cnt_q + 1'b1;
          end else begin
            result_q <= {rem_fix, quo_fix};
            ready_q  <= 1'b1;
            cnt_q    <= '0;
            state_q  <= ST_END;
          end
        end
        ST_END: begin
          if (!start_i) begin
            state_q  <= ST_FREE;
            result_q <= '0;
            ready_q  <= 1'b0;
          end
        end
        default: state_q <= ST_FREE;
      endcase
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - directed self-checking bench for div_unit
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        signed_div_i = 1'b0;
  logic [31:0] opdata1_i = '0;
  logic [31:0] opdata2_i = '0;
  logic        start_i = 1'b0;
  logic        annul_i = 1'b0;
  logic [63:0] result_o;
  logic        ready_o;

  int checks = 0;
  int errors = 0;

  div_unit #(.DataWidth(32), .CntWidth(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a division, scramble operands after E0, count edges until ready_o.
  task automatic run_div(input string name, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp, input int lat);
    int n;
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    n = 0;
    tick();
    n++;
    opdata1_i    = $urandom;
    opdata2_i    = $urandom;
    signed_div_i = ~sgn;
    while (!ready_o && n < 100) begin
      check({name, " result while busy"}, result_o, 64'h0);
      tick();
      n++;
    end
    check({name, " latency"}, 64'(n), 64'(lat));
    check({name, " result"}, result_o, exp);
    tick();
    check({name, " held ready"}, {63'h0, ready_o}, 64'h1);
    check({name, " held result"}, result_o, exp);
    start_i = 1'b0;
    tick();
    check({name, " ready after drop"}, {63'h0, ready_o}, 64'h0);
    check({name, " result after drop"}, result_o, 64'h0);
  endtask

  initial begin
    vecs[0] = '{1'b0, 32'd100,        32'd7,          64'h00000002_0000000E, 34};
    vecs[1] = '{1'b1, 32'hFFFFFFF9,   32'h00000002,   64'hFFFFFFFF_FFFFFFFD, 34};
    vecs[2] = '{1'b1, 32'h00000007,   32'hFFFFFFFE,   64'h00000001_FFFFFFFD, 34};
    vecs[3] = '{1'b1, 32'h12345678,   32'h0,          64'h0,                 2};
    vecs[4] = '{1'b0, 32'hDEADBEEF,   32'h0,          64'h0,                 2};
    vecs[5] = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   64'h00000000_80000000, 34};
    vecs[6] = '{1'b0, 32'hFFFFFFFF,   32'h00000001,   64'h00000000_FFFFFFFF, 34};
    vecs[7] = '{1'b0, 32'hFFFFFFF9,   32'h00000002,   64'h00000001_7FFFFFFC, 34};

    #3;
    check("reset ready", {63'h0, ready_o}, 64'h0);
    check("reset result", result_o, 64'h0);
    rst = 1'b1;
    tick();
    check("idle result", result_o, 64'h0);

    for (int i = 0; i < 8; i++) begin
      run_div($sformatf("vec%0d", i), vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);
      tick();
    end

    // Annul at cnt==10: E0 accepts, E1..E10 bring cnt to 10, E11 sees annul.
    signed_div_i = 1'b0;
    opdata1_i    = 32'd100;
    opdata2_i    = 32'd7;
    start_i      = 1'b1;
    for (int k = 0; k < 11; k++) tick();
    annul_i = 1'b1;
    start_i = 1'b0;
    tick();
    annul_i = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (ready_o) break;
      tick();
    end
    check("annul ready", {63'h0, ready_o}, 64'h0);
    check("annul result", result_o, 64'h0);
    run_div("post-annul 9/3", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 34);
    tick();

    // Asynchronous reset mid-division at cnt==20.
    signed_div_i = 1'b0;
    opdata1_i    = 32'd100;
    opdata2_i    = 32'd7;
    start_i      = 1'b1;
    for (int k = 0; k < 21; k++) tick();
    #2 rst = 1'b0;
    #1;
    check("rst mid ready", {63'h0, ready_o}, 64'h0);
    check("rst mid result", result_o, 64'h0);
    start_i = 1'b0;
    #2 rst = 1'b1;
    tick();
    check("post rst idle ready", {63'h0, ready_o}, 64'h0);
    run_div("post-rst 9/3", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 34);
    tick();

    // Asynchronous reset while a result is being held clears it without a clock.
    signed_div_i = 1'b0;
    opdata1_i    = 32'd100;
    opdata2_i    = 32'd7;
    start_i      = 1'b1;
    for (int k = 0; k < 34; k++) tick();
    check("hold before rst", result_o, 64'h00000002_0000000E);
    #2 rst = 1'b0;
    #1;
    check("rst end ready", {63'h0, ready_o}, 64'h0);
    check("rst end result", result_o, 64'h0);
    start_i = 1'b0;
    #2 rst = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
